// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the fetch unit and the multicycle control FSM:
// opcode/funct values, fetch state codes and the branch offset helper.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] FS_IDLE  = 2'd0;
  localparam logic [1:0] FS_REQ   = 2'd1;
  localparam logic [1:0] FS_WAIT  = 2'd2;
  localparam logic [1:0] FS_ERR   = 2'd3;

  // Branch displacement in bytes: sign-extended word offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC select: JR, J/JAL, taken BEQ/BNE, else sequential.
module next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] ir,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  input  logic [31:0] rs_val,
  output logic [31:0] next_pc
);

  logic take_branch;

  assign take_branch = (beq && zero) || (bne && !zero);

  // NOTE: next_pc gets a default before any branch of the if-chain, so no latch is inferred.
  always_comb begin
    next_pc = pc_plus4;
    if (jump && ir[31:26] == OP_RTYPE) begin
      next_pc = rs_val & ~32'h3;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_offset(ir[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs the imem req/gnt/rvalid
// handshake with a timeout, decodes IR fields and commits next-PC on pc_en.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        pc_en,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        zero,
  input  logic [31:0] rs_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        busy,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] ir;
  logic [31:0] next_pc;
  logic [7:0]  timer;
  logic        rearm_wait;
  logic        start_fetch;
  logic        accept_data;
  logic        timed_out;
  logic        pc_update;

  assign start_fetch = (state == FS_IDLE) && fetch_req && !fetch_err && !rearm_wait;
  assign accept_data = imem_rvalid && ((state == FS_WAIT) || (state == FS_REQ && imem_gnt));
  assign timed_out   = (timer == TIMER_LAST);
  assign pc_update   = pc_en && (busy || instr_valid);

  assign imem_req  = (state == FS_REQ);
  assign imem_addr = fetch_pc;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign imm16  = ir[15:0];
  assign funct  = ir[5:0];

  next_pc_calc u_next_pc (
    .pc_plus4 (pc_plus4),
    .ir       (ir),
    .jump     (jump),
    .beq      (beq),
    .bne      (bne),
    .zero     (zero),
    .rs_val   (rs_val),
    .next_pc  (next_pc)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_IDLE;
      fetch_pc    <= '0;
      ir          <= '0;
      pc_plus4    <= RESET_PC + 32'd4;
      busy        <= 1'b0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      timer       <= '0;
      rearm_wait  <= 1'b0;
    end else begin
      if (rearm_wait && !fetch_req) begin
        rearm_wait <= 1'b0;
      end

      // A completing handshake wins over a timeout expiring in the same cycle.
      if (accept_data) begin
        ir          <= imem_rdata;
        pc_plus4    <= fetch_pc + 32'd4;
        instr_valid <= 1'b1;
        busy        <= 1'b0;
        rearm_wait  <= 1'b1;
        state       <= FS_IDLE;
      end else begin
        case (state)
          FS_IDLE: begin
            if (start_fetch) begin
              state       <= FS_REQ;
              fetch_pc    <= pc;
              instr_valid <= 1'b0;
              busy        <= 1'b1;
              timer       <= '0;
            end
          end
          FS_REQ, FS_WAIT: begin
            if (state == FS_REQ && imem_gnt) begin
              state <= FS_WAIT;
              timer <= '0;
            end else if (timed_out) begin
              state     <= FS_ERR;
              fetch_err <= 1'b1;
              busy      <= 1'b0;
            end else begin
              timer <= timer + 8'd1;
            end
          end
          // ERR is terminal until reset.
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_update) begin
      pc <= next_pc;
    end
  end

endmodule
